// File: rtl/bus_pkg.sv
// Shared types and helpers for the gated datapath bus.
// Imported by the bus mux top level and its priority encoder.
package bus_pkg;

   typedef enum logic {
      BUS_STRICT   = 1'b0,
      BUS_PRIORITY = 1'b1
   } bus_mode_e;

   localparam int BUS_WIDTH = 16;
   localparam int BUS_NSRC  = 4;

   // True when at most one bit is set (zero counts as ok).
   function automatic logic onehot_ok(input logic [63:0] g);
      return (g & (g - 64'd1)) == 64'd0;
   endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Lowest-index-wins priority encoder.
// Also reports whether any and more than one request is set.
module bus_prio_enc
   import bus_pkg::*;
#(
   parameter int N  = BUS_NSRC,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          any,
   output logic          multi
);

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

   assign any   = |req;
   assign multi = ~onehot_ok(64'(req));

endmodule

// File: rtl/bus_gate_keeper.sv
// Zero-latency gated bus mux with a keeper register and
// contention status (sticky flag plus saturating counter).
module bus_gate_keeper
   import bus_pkg::*;
#(
   parameter int WIDTH     = BUS_WIDTH,
   parameter int NSRC      = BUS_NSRC,
   parameter int MODE      = 0,
   parameter int ERR_CNT_W = 8,
   parameter int IDX_W     = $clog2(NSRC)
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [NSRC-1:0]       gate,
   input  logic                  clr_err,
   output logic [WIDTH-1:0]      bus_out,
   output logic                  bus_driven,
   output logic                  contention,
   output logic                  err_sticky,
   output logic [ERR_CNT_W-1:0]  err_count,
   output logic [IDX_W-1:0]      last_src
);

   localparam bit PRIO = (MODE == int'(BUS_PRIORITY));
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   logic [IDX_W-1:0]     win_idx;
   logic                 any_gate;
   logic                 multi_gate;
   logic [WIDTH-1:0]     win_data;

   logic [WIDTH-1:0]     keeper_q, keeper_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic                 sticky_q, sticky_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   bus_prio_enc #(
      .N  (NSRC),
      .IW (IDX_W)
   ) u_enc (
      .req   (gate),
      .idx   (win_idx),
      .any   (any_gate),
      .multi (multi_gate)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (win_idx == IDX_W'(i)) win_data = src_data[i*WIDTH +: WIDTH];
      end
   end

   // Strict mode forces the bus to zero and leaves the keeper alone.
   always_comb begin
      bus_out  = keeper_q;
      keeper_d = keeper_q;
      last_d   = last_q;
      if (any_gate) begin
         if (multi_gate && !PRIO) begin
            bus_out = '0;
         end else begin
            bus_out  = win_data;
            keeper_d = win_data;
            last_d   = win_idx;
         end
      end
   end

   always_comb begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (clr_err) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end
      if (multi_gate) begin
         sticky_d = 1'b1;
         if (clr_err)             cnt_d = ERR_CNT_W'(1);
         else if (cnt_q != CNT_MAX) cnt_d = cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         keeper_q <= '0;
         last_q   <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         keeper_q <= keeper_d;
         last_q   <= last_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus_driven = any_gate;
   assign contention = multi_gate;
   assign err_sticky = sticky_q;
   assign err_count  = cnt_q;
   assign last_src   = last_q;

endmodule

// File: tb/tb_bus_gate_keeper.sv
// Random plus directed bench for bus_gate_keeper in strict,
// priority and narrow-counter configurations against a model.
module tb_bus_gate_keeper;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [63:0] src_data;
   logic [3:0]  gate;
   logic        clr_err;

   logic [15:0] bus0, bus1, bus2;
   logic        drv0, drv1, drv2;
   logic        con0, con1, con2;
   logic        stk0, stk1, stk2;
   logic [7:0]  cnt0, cnt1;
   logic [1:0]  cnt2;
   logic [1:0]  ls0, ls1, ls2;

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned kq[3], lq[3], sq[3], cq[3];
   int unsigned cmax[3] = '{255, 255, 3};
   int          mode[3] = '{0, 1, 0};
   bit          known = 0;

   always #5 Clk = ~Clk;

   bus_gate_keeper #(.MODE(0)) dut0 (
      .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate),
      .clr_err(clr_err), .bus_out(bus0), .bus_driven(drv0),
      .contention(con0), .err_sticky(stk0), .err_count(cnt0),
      .last_src(ls0));

   bus_gate_keeper #(.MODE(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate),
      .clr_err(clr_err), .bus_out(bus1), .bus_driven(drv1),
      .contention(con1), .err_sticky(stk1), .err_count(cnt1),
      .last_src(ls1));

   bus_gate_keeper #(.MODE(0), .ERR_CNT_W(2)) dut2 (
      .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate),
      .clr_err(clr_err), .bus_out(bus2), .bus_driven(drv2),
      .contention(con2), .err_sticky(stk2), .err_count(cnt2),
      .last_src(ls2));

   task automatic check(input string tag, input int unsigned obs,
                        input int unsigned exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned obs_of(input int m, input int f);
      logic [15:0] b;
      logic        d, c, s;
      int unsigned n, l;
      case (m)
         0: begin b = bus0; d = drv0; c = con0; s = stk0; n = cnt0; l = ls0; end
         1: begin b = bus1; d = drv1; c = con1; s = stk1; n = cnt1; l = ls1; end
         default: begin b = bus2; d = drv2; c = con2; s = stk2; n = cnt2; l = ls2; end
      endcase
      case (f)
         0: return b;
         1: return d;
         2: return c;
         3: return s;
         4: return n;
         default: return l;
      endcase
   endfunction

   function automatic int unsigned src_at(input int i);
      return src_data[i*16 +: 16];
   endfunction

   task automatic cyc(input logic [3:0] g, input logic c, input logic r);
      int n, lo;
      int unsigned exp_bus;
      gate = g; clr_err = c; Reset = r;
      n = $countones(g);
      lo = 0;
      while (n > 0 && !g[lo]) lo++;
      #1;
      if (known) begin
         for (int m = 0; m < 3; m++) begin
            if (n == 0)                  exp_bus = kq[m];
            else if (n > 1 && mode[m] == 0) exp_bus = 0;
            else                         exp_bus = src_at(lo);
            check($sformatf("bus_out[%0d]", m), obs_of(m, 0), exp_bus);
            check($sformatf("bus_driven[%0d]", m), obs_of(m, 1), n > 0);
            check($sformatf("contention[%0d]", m), obs_of(m, 2), n > 1);
         end
      end
      @(posedge Clk);
      for (int m = 0; m < 3; m++) begin
         if (r) begin
            kq[m] = 0; lq[m] = 0; sq[m] = 0; cq[m] = 0;
         end else begin
            if (n == 1 || (n > 1 && mode[m] == 1)) begin
               kq[m] = src_at(lo);
               lq[m] = lo;
            end
            if (n > 1) begin
               sq[m] = 1;
               cq[m] = c ? 1 : ((cq[m] < cmax[m]) ? cq[m] + 1 : cmax[m]);
            end else if (c) begin
               sq[m] = 0; cq[m] = 0;
            end
         end
      end
      if (r) known = 1;
      #1;
      if (known) begin
         for (int m = 0; m < 3; m++) begin
            check($sformatf("err_sticky[%0d]", m), obs_of(m, 3), sq[m]);
            check($sformatf("err_count[%0d]", m), obs_of(m, 4), cq[m]);
            check($sformatf("last_src[%0d]", m), obs_of(m, 5), lq[m]);
         end
      end
   endtask

   initial begin
      logic [3:0] g;
      Reset = 1'b1; gate = '0; clr_err = 1'b0;
      src_data = 64'h0;
      cyc(4'b0000, 1'b0, 1'b1);
      cyc(4'b0000, 1'b0, 1'b1);
      check("reset_bus", bus0, 16'h0000);

      src_data = 64'h0000_0000_1234_0000;
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      check("keeper_hold", bus0, 16'h1234);

      src_data = 64'h0000_5555_0000_AAAA;
      repeat (3) cyc(4'b0101, 1'b0, 1'b0);
      check("strict_cnt3", cnt0, 8'd3);
      check("prio_bus", bus1, 16'hAAAA);
      repeat (2) cyc(4'b0101, 1'b0, 1'b0);
      check("sat_cnt", cnt2, 2'd3);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0011, 1'b1, 1'b0);
      check("clr_set_dom", cnt2, 2'd1);

      src_data = 64'h0000_0000_1234_0000;
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b1100, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b1);
      check("mid_reset", bus0, 16'h0000);

      for (int k = 0; k < 400; k++) begin
         src_data = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: g = 4'b0000;
            1: g = 4'b0001 << $urandom_range(0, 3);
            default: g = 4'($urandom);
         endcase
         cyc(g, ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 49) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_gate_keeper.md
Name: bus_gate_keeper

Overview:
Parametrised successor to the datapath bus multiplexer. It selects one of NSRC gated sources onto a WIDTH-bit shared bus with zero latency. When no source is gated, a keeper register holds the last driven value instead of floating the bus. Simultaneous gates are detected, resolved per MODE, and logged in sticky and counting status registers for debug. The block sits between the CPU datapath sources (ALU, PC, MARMUX, MDR, …) and every bus consumer.

Parameters:
WIDTH, 16, bus and source data width in bits
NSRC, 4, number of gated sources (>=2)
MODE, 0, contention policy: 0 = STRICT (drive zero, flag error), 1 = PRIORITY (lowest-index gate wins, flag error)
ERR_CNT_W, 8, width of saturating contention counter
IDX_W, $clog2(NSRC), width of source index

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
src_data  in  NSRC*WIDTH  source i at [i*WIDTH +: WIDTH]
gate  in  NSRC  gate enables; bit i = source i requests bus
clr_err  in  1  clears err_sticky and err_count
bus_out  out  WIDTH  bus value, combinational
bus_driven  out  1  combinational, |gate
contention  out  1  combinational, more than one gate bit set
err_sticky  out  1  registered, set on any contention cycle
err_count  out  ERR_CNT_W  registered, saturating count of contention cycles
last_src  out  IDX_W  registered index of the last source that drove the bus

Behaviour:
- Clock/reset: one clock Clk; Reset is synchronous, active-high, sampled on rising Clk.
- Reset values: keeper = 0, err_sticky = 0, err_count = 0, last_src = 0. bus_out = keeper = 0 while gate = 0. Reset dominates clr_err and contention.
- Exactly one gate bit i set: bus_out = src_data[i] in the same cycle (zero latency). On the next edge, keeper <= src_data[i] and last_src <= i.
- No gate set: bus_out = keeper. Keeper and last_src hold. Never Z/X.
- Contention, MODE 0: bus_out = 0. Keeper and last_src hold.
- Contention, MODE 1: bus_out = src_data[k], where k = lowest set index. Keeper <= src_data[k] and last_src <= k on the edge.
- Any contention cycle: err_sticky <= 1 on the edge. err_count <= err_count+1, saturating at 2^ERR_CNT_W-1 with no wrap.
- clr_err: clears err_sticky and err_count on the edge. If contention occurs in the same cycle, set dominates: err_sticky <= 1, err_count <= 1.
- Reset mid-operation: all registers return to reset values on that edge. Combinational outputs keep following gate/src_data during Reset, with keeper = 0.
- bus_driven and contention depend only on gate. No registered path exists from src_data to bus_out.

Decomposition:
- Shared package bus_pkg:
  - enum bus_mode_e {BUS_STRICT=0, BUS_PRIORITY=1}
  - parameters BUS_WIDTH=16 and BUS_NSRC=4
  - function onehot_ok(gate)
- Sub-module bus_prio_enc: parametrised lowest-index priority encoder. Outputs index, any, and multi. It is reused by future arbitration blocks.
- Top level holds the data mux, keeper, and status registers.

Test Plan:
- Reset 2 cycles, gate=0 -> bus_out=0x0000, err_sticky=0, err_count=0, last_src=0.
- gate=4'b0010, src1=0x1234 -> bus_out=0x1234 same cycle. Then gate=0 -> bus_out stays 0x1234, last_src=1.
- MODE 0, gate=4'b0101, src0=0xAAAA, src2=0x5555 for 3 cycles -> bus_out=0x0000, contention=1, err_sticky=1, err_count=3, keeper unchanged.
- MODE 1, same stimulus -> bus_out=0xAAAA, keeper=0xAAAA, last_src=0, err_count increments.
- ERR_CNT_W=2, 5 contention cycles -> err_count saturates at 3. clr_err alone -> 0. clr_err with contention -> err_sticky=1, err_count=1.
- Reset asserted mid-stream with keeper=0x1234 and err_count=2 -> next edge keeper=0, err_count=0; gate=0 gives bus_out=0x0000.
